// File: rtl/demux_1_4_stream.sv
// 1-to-4 registered stream demultiplexer with a one-entry holding
// register per channel and an accepted-beat counter.
module demux_1_4_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       free;
    logic [3:0]       load;
    logic             accept;
    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A slot draining this cycle can take a new beat in the same cycle.
    assign free     = ~valid_q | out_ready;
    assign in_ready = free[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load    = 4'b0000;
        valid_d = valid_q & ~out_ready;
        cnt_d   = cnt_q;
        if (accept) begin
            load    = 4'b0001 << in_sel;
            valid_d = valid_d | load;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream with a per-channel scoreboard.
module tb_demux_1_4_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'd0;
    logic [31:0] in_data = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b0000;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [15:0] beat_cnt;

    logic        in_ready_w;
    logic [3:0]  out_valid_w;
    logic [31:0] wd0, wd1, wd2, wd3;
    logic [3:0]  beat_cnt_w;

    int checks = 0;
    int errors = 0;
    logic [31:0] q [4][$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    demux_1_4_stream #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .beat_cnt(beat_cnt)
    );

    demux_1_4_stream #(.WIDTH(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data0(wd0), .out_data1(wd1),
        .out_data2(wd2), .out_data3(wd3),
        .beat_cnt(beat_cnt_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] odata(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a beat the bench expects to be accepted at the next edge.
    task automatic send(input logic [1:0] s, input logic [31:0] d,
                        input string tag);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        #0;
        chk(tag, {63'd0, in_ready}, 64'd1);
        q[s].push_back(d);
        exp_cnt++;
    endtask

    // Handshakes seen at the falling edge complete at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("spurious_ch%0d", k), 64'd1, 64'd0);
                    end else begin
                        chk($sformatf("data_ch%0d", k),
                            {32'd0, odata(k)}, {32'd0, q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        // reset then idle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_data", {out_data0, out_data1} | {out_data2, out_data3},
            64'd0);
        chk("rst_cnt", {48'd0, beat_cnt}, 64'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        in_sel = 2'd2;
        #1;
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
        tick();

        // single beat, then stall on the same channel
        out_ready = 4'b0000;
        send(2'd1, 32'hDEADBEEF, "single_ready");
        tick();
        in_data = 32'hCAFEF00D;
        #0;
        chk("single_valid", {60'd0, out_valid}, 64'h2);
        chk("single_data", {32'd0, out_data1}, 64'hDEADBEEF);
        chk("single_cnt", {48'd0, beat_cnt}, 64'd1);
        chk("stall_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("stall_hold", {32'd0, out_data1}, 64'hDEADBEEF);
        chk("stall_cnt", {48'd0, beat_cnt}, 64'd1);
        out_ready = 4'b0010;
        send(2'd1, 32'hCAFEF00D, "drain_accept_ready");
        tick();
        in_valid = 1'b0;
        chk("drain_accept_valid", {60'd0, out_valid}, 64'h2);
        chk("drain_accept_data", {32'd0, out_data1}, 64'hCAFEF00D);
        tick();
        chk("drained", {60'd0, out_valid}, 64'h0);

        // full throughput on channel 3
        out_ready = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            send(2'd3, 32'h3000_0000 + 32'(i), "thru_ready");
            tick();
            chk("thru_valid3", {63'd0, out_valid[3]}, 64'd1);
        end
        in_valid = 1'b0;
        chk("thru_cnt", {48'd0, beat_cnt}, 64'(exp_cnt));
        tick();
        chk("thru_done", {60'd0, out_valid}, 64'h0);
        chk("thru_q3", 64'(q[3].size()), 64'd0);

        // channel isolation
        out_ready = 4'b0000;
        send(2'd0, 32'hA0A0A0A0, "iso_ready0");
        tick();
        send(2'd2, 32'hA2A2A2A2, "iso_ready2");
        tick();
        in_valid = 1'b0;
        in_sel = 2'd0;
        #0;
        chk("iso_valid", {60'd0, out_valid}, 64'h5);
        chk("iso_blocked", {63'd0, in_ready}, 64'd0);
        out_ready = 4'b0101;
        tick();
        chk("iso_drained", {60'd0, out_valid}, 64'h0);
        out_ready = 4'b0000;

        // reset mid-operation
        send(2'd0, 32'h11111111, "mid_ready0");
        tick();
        send(2'd3, 32'h33333333, "mid_ready3");
        tick();
        in_valid = 1'b0;
        chk("mid_full", {60'd0, out_valid}, 64'h9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {60'd0, out_valid}, 64'h0);
        chk("mid_rst_cnt", {48'd0, beat_cnt}, 64'd0);
        for (int k = 0; k < 4; k++) q[k].delete();
        exp_cnt = 0;
        #1 rst_n = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", {60'd0, out_valid}, 64'h0);
        end
        chk("post_rst_cnt", {48'd0, beat_cnt}, 64'd0);

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            send(2'(i), $urandom, "wrap_ready");
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_cnt4", {60'd0, beat_cnt_w}, 64'd1);
        chk("wrap_cnt16", {48'd0, beat_cnt}, 64'd17);
        tick();
        tick();
        chk("final_valid", {60'd0, out_valid}, 64'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("final_q%0d", k), 64'(q[k].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
